// File: rtl/packet_assembler_pkg.sv
// packet_assembler_pkg: shared types for the router input stage.
//   state_t  - framing FSM states (destination, length, data, checksum, output)
//   ERR_*    - values driven on err_code
package packet_assembler_pkg;

  typedef enum logic [2:0] {
    S_DEST,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_OUT
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DEST = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

endpackage

// File: rtl/packet_assembler_checksum_acc.sv
// checksum_acc: running packet checksum, modulo 2^(WIDTH+1).
//   clock, reset : system clock, synchronous active-high reset (sum -> 0)
//   clear        : restart the sum; combined with add, the operand becomes the new sum
//   add          : accumulate operand this cycle
//   operand      : WIDTH-bit word, zero-extended before adding
//   sum          : WIDTH+1-bit registered running sum
module checksum_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] sum_q;
  logic [WIDTH:0] sum_d;
  logic [WIDTH:0] base;

  always_comb begin
    base  = clear ? '0 : sum_q;
    sum_d = add ? base + {1'b0, operand} : base;
  end

  always_ff @(posedge clock) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: router input stage. Frames a packet (dest, len, len data
// words, checksum) from a valid/ready word stream, validates it and presents
// it in parallel to the routing core.
//   clock, reset          : system clock, synchronous active-high reset
//   in_valid/in_ready     : input word handshake; in_data is WIDTH+1 bits
//   abort                 : drop the packet in progress, no error reported
//   pkt_valid/pkt_ready   : output packet handshake
//   pkt_dest/len/data     : assembled packet; unused data lanes read 0
//   err_valid/err_code    : one-cycle error pulse with cause
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 4,
  parameter  int NUM_PORTS = 4,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1),
  localparam int DEST_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH:0]             in_data,
  output logic                       in_ready,
  input  logic                       abort,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [DEST_W-1:0]          pkt_dest,
  output logic [LEN_W-1:0]           pkt_len,
  output logic [MAX_WORDS*WIDTH-1:0] pkt_data,
  output logic                       err_valid,
  output logic [1:0]                 err_code
);

  localparam logic [WIDTH-1:0] PORTS_W = WIDTH'(NUM_PORTS);
  localparam logic [WIDTH-1:0] MAXW_W  = WIDTH'(MAX_WORDS);

  state_t             state_q;
  logic               in_ready_q;
  logic               pkt_valid_q;
  logic               err_valid_q;
  logic [1:0]         err_code_q;
  logic [DEST_W-1:0]  dest_q;
  logic               dest_bad_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   data_q [MAX_WORDS];

  logic [WIDTH-1:0]   word;
  logic               accept;
  logic               len_ok;
  logic               acc_clear;
  logic               acc_add;
  logic [WIDTH:0]     acc_sum;

  assign word   = in_data[WIDTH-1:0];
  // abort wins over a word offered in the same cycle
  assign accept = in_valid && in_ready_q && !abort;
  assign len_ok = (word != '0) && (word <= MAXW_W);

  // The destination word restarts the sum and is its first term
  assign acc_clear = accept && (state_q == S_DEST);
  assign acc_add   = accept && ((state_q == S_DEST) || (state_q == S_DATA) ||
                                ((state_q == S_LEN) && len_ok));

  checksum_acc #(.WIDTH(WIDTH)) u_acc (
    .clock   (clock),
    .reset   (reset),
    .clear   (acc_clear),
    .add     (acc_add),
    .operand (word),
    .sum     (acc_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_DEST;
      in_ready_q  <= 1'b1;
      pkt_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      dest_q      <= '0;
      dest_bad_q  <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < MAX_WORDS; i++) data_q[i] <= '0;
    end else begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      if (abort) begin
        state_q     <= S_DEST;
        in_ready_q  <= 1'b1;
        pkt_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_DEST: if (accept) begin
            dest_q     <= word[DEST_W-1:0];
            dest_bad_q <= (word >= PORTS_W);
            cnt_q      <= '0;
            for (int i = 0; i < MAX_WORDS; i++) data_q[i] <= '0;
            state_q    <= S_LEN;
          end
          S_LEN: if (accept) begin
            if (!len_ok) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_LEN;
              state_q     <= S_DEST;
            end else begin
              len_q   <= word[LEN_W-1:0];
              state_q <= S_DATA;
            end
          end
          S_DATA: if (accept) begin
            for (int i = 0; i < MAX_WORDS; i++)
              if (cnt_q == LEN_W'(i)) data_q[i] <= word;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_q <= S_CHECK;
          end
          S_CHECK: if (accept) begin
            // A bad destination is reported even if the checksum is also wrong
            if (dest_bad_q) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_DEST;
              state_q     <= S_DEST;
            end else if (in_data != acc_sum) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
              state_q     <= S_DEST;
            end else begin
              state_q     <= S_OUT;
              pkt_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
          S_OUT: if (pkt_ready) begin
            state_q     <= S_DEST;
            pkt_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
          default: begin
            state_q     <= S_DEST;
            pkt_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_lane
      assign pkt_data[gi*WIDTH +: WIDTH] = data_q[gi];
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_dest  = dest_q;
  assign pkt_len   = len_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_packet_assembler.sv
module tb_packet_assembler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [1:0]  pkt_dest;
  logic [2:0]  pkt_len;
  logic [31:0] pkt_data;
  logic        err_valid;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_bad = 0;
  int gap_max = 0;
  int cyc = 0;

  packet_assembler dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dest  (pkt_dest),
    .pkt_len   (pkt_len),
    .pkt_data  (pkt_data),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference checksum: plain arithmetic sum of the framed words, mod 512
  function automatic logic [8:0] model_csum(input int dest, input int len, input logic [31:0] dw);
    int s;
    s = dest + len;
    for (int i = 0; i < len && i < 4; i++) s += int'((dw >> (8 * i)) & 32'hFF);
    return 9'(s % 512);
  endfunction

  task automatic send_word(input logic [8:0] w);
    int waitc;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int g = 0; g < gap; g++) tick();
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, waitc);
    end
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Drives one whole packet and checks the outcome against the reference rules.
  task automatic send_packet(input int dest, input int len, input logic [31:0] dw,
                             input logic [8:0] csum, input int hold, input bit abort_out);
    logic [1:0]  exp_code;
    logic [63:0] m;
    logic [31:0] exp_data;
    send_word(9'(dest));
    send_word(9'(len));
    if (len == 0 || len > 4) begin
      n_vec++;
      if (err_valid !== 1'b1 || err_code !== 2'b10 || pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL len_err: err_valid=%b err_code=%b pkt_valid=%b, required 1 10 0",
                 err_valid, err_code, pkt_valid);
      end
      tick();
      n_vec++;
      if (err_valid !== 1'b0 || err_code !== 2'b00) begin
        n_bad++;
        $display("FAIL len_err_pulse: err_valid=%b err_code=%b, required 0 00", err_valid, err_code);
      end
      $display("pkt dest=%0d len=%0d -> length error", dest, len);
      return;
    end
    for (int i = 0; i < len; i++) begin
      send_word({1'b0, dw[8*i +: 8]});
      n_vec++;
      if (err_valid !== 1'b0 || pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL data_quiet: err_valid=%b pkt_valid=%b, required 0 0", err_valid, pkt_valid);
      end
    end
    send_word(csum);
    if (dest >= 4)                             exp_code = 2'b01;
    else if (csum != model_csum(dest, len, dw)) exp_code = 2'b11;
    else                                       exp_code = 2'b00;
    if (exp_code != 2'b00) begin
      n_vec++;
      if (err_valid !== 1'b1 || err_code !== exp_code || pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL pkt_err: err_valid=%b err_code=%b pkt_valid=%b, required 1 %b 0",
                 err_valid, err_code, pkt_valid, exp_code);
      end
      tick();
      n_vec++;
      if (err_valid !== 1'b0 || err_code !== 2'b00 || pkt_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL pkt_err_pulse: err_valid=%b err_code=%b pkt_valid=%b, required 0 00 0",
                 err_valid, err_code, pkt_valid);
      end
      $display("pkt dest=%0d len=%0d csum=%03h -> error %b", dest, len, csum, exp_code);
      return;
    end
    m = (64'd1 << (8 * len)) - 64'd1;
    exp_data = dw & m[31:0];
    for (int c = 0; c <= hold; c++) begin
      n_vec++;
      if (pkt_valid !== 1'b1 || in_ready !== 1'b0 || err_valid !== 1'b0 ||
          pkt_dest !== 2'(dest) || pkt_len !== 3'(len) || pkt_data !== exp_data) begin
        n_bad++;
        $display("FAIL pkt_out: valid=%b ready=%b err=%b dest=%0d len=%0d data=%08h, required 1 0 0 %0d %0d %08h",
                 pkt_valid, in_ready, err_valid, pkt_dest, pkt_len, pkt_data, dest, len, exp_data);
      end
      if (c < hold) tick();
    end
    if (abort_out) abort = 1'b1;
    else           pkt_ready = 1'b1;
    tick();
    abort = 1'b0;
    pkt_ready = 1'b0;
    n_vec++;
    if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || err_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pkt_release: pkt_valid=%b in_ready=%b err_valid=%b, required 0 1 0",
               pkt_valid, in_ready, err_valid);
    end
    $display("pkt dest=%0d len=%0d data=%08h -> delivered%s", dest, len, exp_data,
             abort_out ? " then aborted" : "");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 9'h1AA;
    pkt_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || pkt_valid !== 1'b0 || pkt_dest !== 2'd0 || pkt_len !== 3'd0 ||
        pkt_data !== 32'd0 || err_valid !== 1'b0 || err_code !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b valid=%b dest=%0d len=%0d data=%08h err=%b code=%b, required 1 0 0 0 0 0 00",
               in_ready, pkt_valid, pkt_dest, pkt_len, pkt_data, err_valid, err_code);
    end
    in_valid = 1'b0;
    pkt_ready = 1'b0;
    reset = 1'b0;
    tick();
    $display("reset applied");
  endtask

  task automatic test_directed();
    send_packet(2, 3, 32'h00332211, 9'h06B, 0, 0);
    send_packet(2, 3, 32'h00332211, 9'h06C, 0, 0);
    send_packet(2, 3, 32'h00332211, 9'h06B, 0, 0);
    send_packet(1, 0, 32'h0, 9'h0, 0, 0);
    send_packet(0, 1, 32'h0000007E, 9'h07F, 0, 0);
    send_packet(1, 5, 32'h0, 9'h0, 0, 0);
    send_packet(3, 2, 32'h0000A05A, 9'h0FF, 0, 0);
    send_packet(3, 4, 32'hFFFFFFFF, 9'h003, 0, 0);
    send_packet(5, 2, 32'h00000201, 9'h00A, 0, 0);
    send_packet(5, 2, 32'h00000201, 9'h00B, 0, 0);
  endtask

  task automatic test_backpressure();
    send_packet(1, 4, 32'h44332211, model_csum(1, 4, 32'h44332211), 5, 0);
  endtask

  task automatic test_abort();
    send_word(9'd1);
    send_word(9'd3);
    send_word(9'h0AA);
    in_valid = 1'b1;
    abort = 1'b1;
    in_data = 9'h055;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    n_vec++;
    if (err_valid !== 1'b0 || pkt_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_data: err_valid=%b pkt_valid=%b in_ready=%b, required 0 0 1",
               err_valid, pkt_valid, in_ready);
    end
    $display("abort mid-data");
    send_packet(2, 2, 32'h00009988, model_csum(2, 2, 32'h00009988), 0, 0);
    send_packet(0, 1, 32'h00000042, model_csum(0, 1, 32'h00000042), 2, 1);
    send_packet(3, 3, 32'h00123456, model_csum(3, 3, 32'h00123456), 0, 0);
  endtask

  task automatic test_reset_mid_packet();
    send_word(9'd2);
    send_word(9'd3);
    send_word(9'h011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || pkt_valid !== 1'b0 || pkt_dest !== 2'd0 || pkt_len !== 3'd0 ||
        pkt_data !== 32'd0 || err_valid !== 1'b0 || err_code !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid: ready=%b valid=%b dest=%0d len=%0d data=%08h err=%b code=%b, required 1 0 0 0 0 0 00",
               in_ready, pkt_valid, pkt_dest, pkt_len, pkt_data, err_valid, err_code);
    end
    $display("reset mid-packet");
    send_packet(2, 3, 32'h00332211, 9'h06B, 0, 0);
  endtask

  task automatic test_back_to_back();
    int c0;
    int len;
    gap_max = 0;
    for (int k = 0; k < 4; k++) begin
      len = k + 1;
      c0 = cyc;
      send_packet(k, len, 32'hC3B2A190 + k, model_csum(k, len, 32'hC3B2A190 + k), 0, 0);
      n_vec++;
      if (cyc - c0 !== len + 4) begin
        n_bad++;
        $display("FAIL throughput: %0d cycles for len %0d, required %0d", cyc - c0, len, len + 4);
      end
    end
  endtask

  task automatic test_random();
    int dest;
    int len;
    logic [31:0] dw;
    logic [8:0] cs;
    gap_max = 2;
    for (int k = 0; k < 40; k++) begin
      dest = int'($urandom_range(0, 5));
      len  = ($urandom_range(0, 7) == 0) ? ((k % 2 == 0) ? 0 : int'($urandom_range(5, 9)))
                                         : int'($urandom_range(1, 4));
      dw   = $urandom;
      cs   = model_csum(dest, len, dw);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 9'(1 << $urandom_range(0, 8));
      send_packet(dest, len, dw, cs, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end
    gap_max = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
# packet_assembler

Input stage of the router. It collects a variable-length packet word by word from the switch/push-button front end using a valid/ready handshake, and validates its destination, length and checksum. It presents the complete packet in parallel to the routing core. Malformed packets are dropped and reported with an error code.

## Interface
- WIDTH, 8: payload word width; input words are WIDTH+1 bits wide, so they can carry the checksum.
- MAX_WORDS, 4: maximum data words per packet.
- NUM_PORTS, 4: number of router output ports; legal destinations are 0..NUM_PORTS-1.
- Derived: LEN_W = $clog2(MAX_WORDS+1), DEST_W = $clog2(NUM_PORTS).

Ports:
- Clock and reset: reset is synchronous and active-high; the clock is `clock`.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- in_valid  in  1  input word valid.
- in_data  in  WIDTH+1  input word.
- in_ready  out  1  block can accept a word.
- abort  in  1  synchronous; discard the packet in progress.
- pkt_valid  out  1  assembled packet available.
- pkt_ready  in  1  routing core consumes the packet.
- pkt_dest  out  DEST_W  destination port.
- pkt_len  out  LEN_W  number of data words.
- pkt_data  out  MAX_WORDS*WIDTH  data; word i is at [i*WIDTH +: WIDTH]; unused lanes are 0.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error code: 01 = bad destination, 10 = bad length, 11 = checksum mismatch; 00 when idle.

## Operation
- A word is accepted on a rising edge where in_valid && in_ready.
- Packet format, in order: destination word, length word, length data words, checksum word.
- Destination, length and data use only in_data[WIDTH-1:0]; the checksum uses the full WIDTH+1 bits.
- Checksum is the sum of the low WIDTH bits of the destination, length and every data word, zero-extended, mod 2^(WIDTH+1).
- FSM states:
  - S_DEST: accepting a word clears the data buffer and the accumulator; latches the destination; records dest_bad if the value is >= NUM_PORTS; goes to S_LEN.
  - S_LEN: a length of 0 or > MAX_WORDS pulses err 10 and returns to S_DEST. Otherwise the length is latched and the FSM goes to S_DATA.
  - S_DATA: stores the word at lane index cnt and increments cnt. When cnt reaches len-1 on an accepted word, goes to S_CHECK.
  - S_CHECK: on accept:
    - if dest_bad, err 01 and go to S_DEST;
    - else if the checksum mismatches, err 11 and go to S_DEST;
    - else go to S_OUT.
  - S_OUT: pkt_valid=1 and in_ready=0. Outputs are held stable until pkt_valid && pkt_ready, then the FSM goes to S_DEST.
- A bad destination does not stop framing: the rest of the packet is consumed, then dropped.
- Bad-destination error takes priority over checksum error.
- abort in any state, including S_OUT: go to S_DEST next cycle, drop the packet, no error pulse. abort beats in_valid in the same cycle; that word is discarded.

## Timing
- Reset values:
  - state = S_DEST; in_ready = 1.
  - pkt_valid = 0; pkt_dest, pkt_len and pkt_data = 0.
  - err_valid = 0; err_code = 00; accumulator = 0.
- in_ready = 1 in every state except S_OUT; it is registered from state with no combinational path from pkt_ready.
- pkt_valid rises the cycle after the checksum word is accepted.
- After the output handshake, in_ready rises the next cycle; there is no bypass.
- err_valid/err_code pulse for exactly one cycle, the cycle after the offending word is accepted.
- Minimum packet throughput: len+4 cycles per packet (len+3 input words plus the S_OUT handshake cycle).
- Reset mid-packet: the behaviour is identical to power-on reset.

## Structure
- Package packet_assembler_pkg: state enum (S_DEST, S_LEN, S_DATA, S_CHECK, S_OUT) and err_code constants ERR_NONE, ERR_DEST, ERR_LEN, ERR_CSUM.
- One sub-module, checksum_acc (WIDTH): clear, add-enable, WIDTH-bit operand, WIDTH+1-bit running sum.

## Test plan
- WIDTH=8, NUM_PORTS=4, good packet: dest 2, len 3, data 0x11 0x22 0x33, checksum 0x06B -> pkt_valid, pkt_dest=2, pkt_len=3, pkt_data=0x00332211, no error.
- Same packet with checksum 0x06C -> err 11 pulses one cycle after the checksum word; pkt_valid stays 0; the next packet is accepted normally.
- len=0 and, separately, len=5 -> err 10 one cycle after the length word; the next word is treated as a destination.
- Wrap-around: dest 3, len 4, data 0xFF×4, checksum 0x003 (0x403 mod 512) -> packet accepted.
- Bad destination: dest 5, correct checksum -> err 01 only after the checksum word; no pkt_valid.
- Backpressure and abort:
  - Hold pkt_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout; pkt_ready=1 -> in_ready=1 the next cycle.
  - Assert abort together with in_valid mid-data -> packet dropped, no error; the following good packet is correct.
